spi_slave_adc_emu: RTL and testbench
====================================

Name: spi_slave_adc_emu

Overview:
- SPI responder that emulates the 8-bit serial ADC read by the lab06 SPI master, so that master can be exercised on-board and in simulation without the physical converter.
- Samples the master's cs_n/sclk with the system clock, loads an 8-bit sample at frame start and shifts it out on sdata.
- Frame: 16 sclk cycles; 3 leading zeros, 8 data bits MSB first, 5 trailing zeros. The master captures on sclk rising edges 4..11.
- Sits between a sample source (switches, counter or test pattern) and the board's sdata line.

Parameters:
- DATA_W, 8, sample width in bits.
- LEAD_BITS, 3, zero bits driven before the MSB.
- FRAME_BITS, 16, sclk falling edges per frame.
- SYNC_STAGES, 2, synchronizer flops on cs_n and sclk (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  DATA_W  next sample value.
- sample_valid  in  1  writes sample_in into the holding register.
- cs_n  in  1  chip select from master, asynchronous, active-low.
- sclk  in  1  serial clock from master, asynchronous, idles high.
- sdata  out  1  serial data to master.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a complete frame ends.
- frame_abort  out  1  one-cycle pulse when cs_n deasserts before FRAME_BITS falls.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: sdata=0, busy=0, frame_done=0, frame_abort=0, holding register=0, shift register=0, fall counter=0, state=IDLE. Synchronizer flops reset to 1, which is the idle level of both cs_n and sclk.
- cs_n and sclk each pass through SYNC_STAGES flops plus one history flop. The edge strobes cs_fall, cs_rise and sclk_fall are single-cycle pulses.
- Latency: sdata updates on the (SYNC_STAGES+1)th clk edge after raw sclk is first sampled low.
- Requirement on the master: sclk half-period ≥ SYNC_STAGES+3 clk cycles. The master's default is 13.
- Holding register:
  - Loads sample_in whenever sample_valid=1, in any state.
  - If sample_valid coincides with cs_fall, the new sample_in goes straight into the shift register.
- State machine:
  - IDLE: sdata=0, busy=0. On cs_fall: load shift register, clear fall counter, go to ACTIVE.
  - ACTIVE: busy=1. On each sclk_fall, increment the fall counter (5 bits) and set sdata as follows, where k is the new count:
    - k = 1..LEAD_BITS: 0.
    - k = LEAD_BITS+1..LEAD_BITS+DATA_W: shift register MSB, then shift left one bit.
    - k > LEAD_BITS+DATA_W: 0.
  - ACTIVE: when k reaches FRAME_BITS, go to DONE.
  - ACTIVE: on cs_rise, pulse frame_abort, set sdata=0, go to IDLE.
  - DONE: busy=1, sdata=0. Further sclk_fall edges are ignored and the counter saturates. On cs_rise, pulse frame_done and go to IDLE.
- Between cs_fall and the first sclk_fall, sdata=0.
- sclk activity while cs_n is high is ignored.
- If cs_rise and sclk_fall occur in the same cycle, cs_rise wins.
- If cs_fall occurs in the same cycle as the transition to IDLE, the new frame is not started. The master must hold cs_n high for ≥2 clk cycles.
- A sample_valid write during a frame does not disturb the bits currently being shifted out.
- Asserting rst mid-frame returns everything to reset values immediately, with no pulses. The next frame needs a fresh cs_fall.

Decomposition:
- Package spi_adc_pkg holds:
  - state encoding (IDLE, ACTIVE, DONE);
  - default constants DATA_W, LEAD_BITS and FRAME_BITS;
  - fall-counter width, 5 bits.
- Sub-module sync_edge_det: a SYNC_STAGES synchronizer with history flop that outputs the synchronized level plus rise and fall strobes. It is instantiated twice, once for cs_n and once for sclk.

Test Plan:
- Hold sample_in=8'hA5 (pulse sample_valid), run one 16-clock frame with half-period 13 -> bits captured at rises 1..16 are 000_10100101_00000, frame_done pulses once, busy returns to 0.
- Connect to the SPI master with samples 8'h00, 8'hFF and 8'h5A in consecutive frames -> master led shows 00, FF, 5A respectively.
- cs_n rises after 6 sclk falls -> frame_abort pulses once, frame_done stays 0, sdata=0. The next full frame with 8'h3C reads 3C.
- sample_valid with 8'hC3 asserted on the same cycle as synchronized cs_fall (holding register =8'h11) -> frame shifts out C3. A sample_valid of 8'h77 mid-frame does not alter the current frame; the next frame reads 77.
- Toggle sclk 20 times with cs_n high -> sdata stays 0 and busy stays 0. Send 20 falls within one frame -> the extra 4 are ignored and sdata stays 0 after fall 16.
- Assert rst at fall 7 of a frame carrying 8'hF0 -> all outputs go to 0 immediately with no pulse. The following frame with 8'h0F reads 0F.

Source files
------------

// File: rtl/spi_slave_adc_emu_pkg.sv
// ----------------------------------------------------------------------------
// spi_adc_pkg
// Shared definitions for the SPI ADC emulator.
// Contents:
//   state_e                      - frame state machine encoding
//   DEF_DATA_W                   - default sample width
//   DEF_LEAD_BITS                - default zero bits ahead of the MSB
//   DEF_FRAME_BITS               - default sclk falling edges per frame
//   DEF_SYNC_STAGES              - default synchronizer depth
//   CNT_W                        - fall-counter width
//   in_data_window()             - true when fall count k selects a data bit
// ----------------------------------------------------------------------------
package spi_adc_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_LEAD_BITS   = 3;
    localparam int unsigned DEF_FRAME_BITS  = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Five bits covers FRAME_BITS up to 31.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Counts k in (lead, lead + data_w] carry a sample bit; all others drive 0.
    function automatic logic in_data_window(
        input logic [CNT_W-1:0] k,
        input logic [CNT_W-1:0] last_lead,
        input logic [CNT_W-1:0] last_data
    );
        return (k > last_lead) && (k <= last_data);
    endfunction

endpackage

// File: rtl/spi_slave_adc_emu_if.sv
// ----------------------------------------------------------------------------
// spi_slave_adc_emu_if
// Three-wire SPI link between the lab06 master and the ADC emulator.
// Signals:
//   cs_n   - chip select, active low, driven by the master
//   sclk   - serial clock, idles high, driven by the master
//   sdata  - serial data, driven by the emulator
// Modports:
//   master - drives cs_n/sclk, reads sdata
//   slave  - reads cs_n/sclk, drives sdata
// ----------------------------------------------------------------------------
interface spi_slave_adc_emu_if;

    logic cs_n;
    logic sclk;
    logic sdata;

    modport master (
        output cs_n,
        output sclk,
        input  sdata
    );

    modport slave (
        input  cs_n,
        input  sclk,
        output sdata
    );

endinterface

// File: rtl/spi_slave_adc_emu_sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a SYNC_STAGES
// flop chain, then compares against one history flop to produce edge strobes.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   i_async  in   raw asynchronous input
//   o_level  out  synchronized level
//   o_rise   out  one-cycle strobe on a synchronized 0->1 transition
//   o_fall   out  one-cycle strobe on a synchronized 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Fewer than two stages is not a synchronizer; clamp rather than fail.
    localparam int unsigned N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] r_sync;
    logic         r_hist;

    // Reset to the idle level so leaving reset never fabricates an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {N{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[N-2:0], i_async};
            r_hist <= r_sync[N-1];
        end
    end

    assign o_level = r_sync[N-1];
    assign o_rise  = r_sync[N-1] & ~r_hist;
    assign o_fall  = ~r_sync[N-1] & r_hist;

endmodule

// File: rtl/spi_slave_adc_emu.sv
// ----------------------------------------------------------------------------
// spi_slave_adc_emu
// Emulates the 8-bit serial ADC read by the lab06 SPI master. A sample is
// latched at frame start and shifted out MSB first after LEAD_BITS zeros;
// the remainder of the frame reads as zeros.
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous, active-high reset
//   i_sample_in     in   next sample value (DATA_W bits)
//   i_sample_valid  in   writes i_sample_in into the holding register
//   spi_if          --   slave side of the SPI link (cs_n, sclk in; sdata out)
//   o_busy          out  high while a frame is in progress
//   o_frame_done    out  one-cycle pulse when a complete frame ends
//   o_frame_abort   out  one-cycle pulse when cs_n rises before FRAME_BITS falls
// ----------------------------------------------------------------------------
module spi_slave_adc_emu
    import spi_adc_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LEAD_BITS   = DEF_LEAD_BITS,
    parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   i_sample_in,
    input  logic                i_sample_valid,
    spi_slave_adc_emu_if.slave  spi_if,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_frame_abort
);

    localparam logic [CNT_W-1:0] LAST_LEAD = CNT_W'(LEAD_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(LEAD_BITS + DATA_W);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BITS);

    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_unused_sclk_level;
    logic w_unused_sclk_rise;
    logic w_sclk_fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_if.cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_if.sclk),
        .o_level (w_unused_sclk_level),
        .o_rise  (w_unused_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    state_e            r_state;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sdata;
    logic              r_busy;
    logic              r_done;
    logic              r_abort;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_sclk_fall_sel;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Only count sclk falls while the synchronized select is still low.
    assign w_sclk_fall_sel = w_sclk_fall & ~w_cs_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_hold  <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sdata <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;

            // Holding register is written in every state; the shift register
            // only picks it up at frame start, so mid-frame writes are safe.
            if (i_sample_valid) begin
                r_hold <= i_sample_in;
            end

            unique case (r_state)
                StIdle: begin
                    r_sdata <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_cs_fall) begin
                        // A write landing on the start cycle bypasses the hold.
                        r_shift <= i_sample_valid ? i_sample_in : r_hold;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StActive;
                    end
                end

                StActive: begin
                    r_busy <= 1'b1;
                    // cs_rise takes priority over a coincident sclk fall.
                    if (w_cs_rise) begin
                        r_abort <= 1'b1;
                        r_sdata <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (w_sclk_fall_sel) begin
                        r_cnt <= w_cnt_inc;
                        if (in_data_window(w_cnt_inc, LAST_LEAD, LAST_DATA)) begin
                            r_sdata <= r_shift[DATA_W-1];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end else begin
                            r_sdata <= 1'b0;
                        end
                        if (w_cnt_inc >= FRAME_END) begin
                            r_state <= StDone;
                        end
                    end
                end

                StDone: begin
                    // Extra sclk falls are ignored; the counter holds its value.
                    r_sdata <= 1'b0;
                    r_busy  <= 1'b1;
                    if (w_cs_rise) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_sdata <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign spi_if.sdata  = r_sdata;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_done;
    assign o_frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_adc_emu.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_adc_emu
// Drives the emulator as the lab06 master would (sclk half-period 13 clk),
// captures sdata on every sclk rise and compares against hand-computed frames.
// ----------------------------------------------------------------------------
module tb_spi_slave_adc_emu;

    localparam int HALF = 13;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;

    spi_slave_adc_emu_if u_if ();

    spi_slave_adc_emu u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_in    (sample_in),
        .i_sample_valid (sample_valid),
        .spi_if         (u_if),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_frame_abort  (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int done_cnt;
    int abort_cnt;
    int busy_cnt;
    int sdata_cnt;

    always @(negedge clk) begin
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (frame_abort) abort_cnt = abort_cnt + 1;
        if (busy)        busy_cnt  = busy_cnt + 1;
        if (u_if.sdata)  sdata_cnt = sdata_cnt + 1;
    end

    typedef struct {
        logic        pre_en;
        logic [7:0]  pre_val;
        logic        coin_en;
        logic [7:0]  coin_val;
        logic        mid_en;
        logic [7:0]  mid_val;
        int          nfalls;
        logic [19:0] exp_cap;
        int          exp_done;
        int          exp_abort;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        abort_cnt = 0;
        busy_cnt  = 0;
        sdata_cnt = 0;
    endtask

    // One master frame; cap collects sdata at each sclk rise, first bit highest.
    task automatic do_frame(input vec_t v, output logic [19:0] cap);
        cap = '0;
        if (v.pre_en) begin
            sample_in    = v.pre_val;
            sample_valid = 1'b1;
            wait_clks(1);
            sample_valid = 1'b0;
            wait_clks(1);
        end
        clear_counts();
        u_if.cs_n = 1'b0;
        if (v.coin_en) begin
            // Two sync stages: the cs_fall strobe is live on the third edge.
            wait_clks(2);
            sample_in    = v.coin_val;
            sample_valid = 1'b1;
            wait_clks(1);
            sample_valid = 1'b0;
            wait_clks(HALF - 3);
        end else begin
            wait_clks(HALF);
        end
        for (int i = 0; i < v.nfalls; i++) begin
            u_if.sclk = 1'b0;
            if (v.mid_en && i == 4) begin
                wait_clks(1);
                sample_in    = v.mid_val;
                sample_valid = 1'b1;
                wait_clks(1);
                sample_valid = 1'b0;
                wait_clks(HALF - 2);
            end else begin
                wait_clks(HALF);
            end
            u_if.sclk = 1'b1;
            cap = {cap[18:0], u_if.sdata};
            wait_clks(HALF);
        end
        u_if.cs_n = 1'b1;
        wait_clks(8);
    endtask

    logic [19:0] cap;
    vec_t        v0f;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        clear_counts();
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        u_if.cs_n    = 1'b1;
        u_if.sclk    = 1'b1;

        //        pre   pre_v  coin  coin_v mid   mid_v  n   exp_cap     done abort
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h014A0, 1, 0};
        vecs[1] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h00000, 1, 0};
        vecs[2] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h01FE0, 1, 0};
        vecs[3] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h00B40, 1, 0};
        vecs[4] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00,  6, 20'h00001, 0, 1};
        vecs[5] = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h00780, 1, 0};
        vecs[6] = '{1'b1, 8'h11, 1'b1, 8'hC3, 1'b1, 8'h77, 16, 20'h01860, 1, 0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h00EE0, 1, 0};
        vecs[8] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 20, 20'h0AA00, 1, 0};

        wait_clks(3);
        check("reset sdata", 32'(u_if.sdata), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(frame_done), 0);
        check("reset abort", 32'(frame_abort), 0);
        rst = 1'b0;
        wait_clks(4);

        // sclk toggling with cs_n high must be ignored.
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            u_if.sclk = 1'b0;
            wait_clks(5);
            u_if.sclk = 1'b1;
            wait_clks(5);
        end
        check("idle sclk busy cycles", 32'(busy_cnt), 0);
        check("idle sclk sdata cycles", 32'(sdata_cnt), 0);
        check("idle sclk pulses", 32'(done_cnt + abort_cnt), 0);

        for (int n = 0; n < 9; n++) begin
            do_frame(vecs[n], cap);
            check($sformatf("v%0d captured bits", n), 32'(cap), 32'(vecs[n].exp_cap));
            check($sformatf("v%0d frame_done pulses", n), 32'(done_cnt), 32'(vecs[n].exp_done));
            check($sformatf("v%0d frame_abort pulses", n), 32'(abort_cnt),
                  32'(vecs[n].exp_abort));
            check($sformatf("v%0d busy during frame", n), 32'(busy_cnt != 0), 1);
            check($sformatf("v%0d busy after frame", n), 32'(busy), 0);
            check($sformatf("v%0d sdata after frame", n), 32'(u_if.sdata), 0);
        end

        // Reset at fall 7 of an F0 frame: sdata is mid-sample (1) before reset.
        sample_in    = 8'hF0;
        sample_valid = 1'b1;
        wait_clks(1);
        sample_valid = 1'b0;
        wait_clks(1);
        clear_counts();
        u_if.cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 7; i++) begin
            u_if.sclk = 1'b0;
            wait_clks(HALF);
            if (i < 6) begin
                u_if.sclk = 1'b1;
                wait_clks(HALF);
            end
        end
        check("pre-reset sdata at fall 7", 32'(u_if.sdata), 1);
        check("pre-reset busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async reset sdata", 32'(u_if.sdata), 0);
        check("async reset busy", 32'(busy), 0);
        u_if.cs_n = 1'b1;
        u_if.sclk = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);
        check("reset episode pulses", 32'(done_cnt + abort_cnt), 0);
        check("post-reset busy", 32'(busy), 0);

        v0f = '{1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, 16, 20'h001E0, 1, 0};
        do_frame(v0f, cap);
        check("post-reset 0F bits", 32'(cap), 32'(v0f.exp_cap));
        check("post-reset 0F done", 32'(done_cnt), 1);
        check("post-reset 0F abort", 32'(abort_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
